// File: rtl/la_iodebounce.sv
// Pad input conditioner: synchronizer, programmable debounce filter, edge pulses and a
// sticky mode-selectable interrupt flag.
module la_iodebounce #(
  parameter int SYNCW = 2,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            z,
  input  logic            en,
  input  logic [CNTW-1:0] thresh,
  input  logic [1:0]      irqmode,
  input  logic            clr,
  output logic            out,
  output logic            rise,
  output logic            fall,
  output logic            irq
);

  typedef enum logic [0:0] {StStable, StPend} state_e;

  state_e          state_q, state_d;
  logic [SYNCW-1:0] sync_q;
  logic            s;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            out_q, out_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            irq_q, irq_d;
  logic            commit;
  logic            irq_set;

  assign s = sync_q[SYNCW-1];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNCW-2:0], z};
    end
  end

  // The first mismatching cycle counts as cycle 0, so a new level is accepted after
  // thresh+1 consecutive mismatching cycles; thresh=0 commits immediately.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StStable: begin
        cnt_d = '0;
        if (en && (s != out_q)) begin
          if (thresh == '0) begin
            commit = 1'b1;
          end else begin
            cnt_d   = CNTW'(1);
            state_d = StPend;
          end
        end
      end
      StPend: begin
        if (!en || (s == out_q)) begin
          cnt_d   = '0;
          state_d = StStable;
        end else if (cnt_q >= thresh) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StStable;
      end
    endcase
    if (commit) begin
      out_d   = s;
      rise_d  = s;
      fall_d  = ~s;
      cnt_d   = '0;
      state_d = StStable;
    end
  end

  // A set on the same edge as a clear takes priority.
  always_comb begin
    irq_set = (rise_d & irqmode[0]) | (fall_d & irqmode[1]);
    irq_d   = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StStable;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      irq_q   <= irq_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_la_iodebounce.sv
// Directed and randomized bench for la_iodebounce against a cycle-level behavioural model.
module tb_la_iodebounce;

  localparam int SYNCW = 2;
  localparam int CNTW  = 8;

  logic            clk = 1'b0;
  logic            nreset;
  logic            z;
  logic            en;
  logic [CNTW-1:0] thresh;
  logic [1:0]      irqmode;
  logic            clr;
  logic            out, rise, fall, irq;

  int checks   = 0;
  int failures = 0;

  // Model: z history (index 0 newest), accepted level, mismatch run length, flags.
  bit zh[SYNCW];
  bit m_out, m_rise, m_fall, m_irq;
  int run;

  la_iodebounce #(.SYNCW(SYNCW), .CNTW(CNTW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .z      (z),
    .en     (en),
    .thresh (thresh),
    .irqmode(irqmode),
    .clr    (clr),
    .out    (out),
    .rise   (rise),
    .fall   (fall),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < SYNCW; i++) zh[i] = 1'b0;
    m_out = 0; m_rise = 0; m_fall = 0; m_irq = 0; run = 0;
  endtask

  // Applies one clock edge using the input values held across that edge.
  task automatic model_edge();
    bit s;
    bit nr, nf;
    s  = zh[SYNCW-1];
    nr = 0;
    nf = 0;
    if (en && (s != m_out)) begin
      run++;
      if (run > int'(thresh)) begin
        m_out = s;
        nr    = s;
        nf    = !s;
        run   = 0;
      end
    end else begin
      run = 0;
    end
    m_rise = nr;
    m_fall = nf;
    if ((nr && irqmode[0]) || (nf && irqmode[1])) m_irq = 1;
    else if (clr) m_irq = 0;
    for (int i = SYNCW - 1; i > 0; i--) zh[i] = zh[i-1];
    zh[0] = z;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"},  out,  m_out);
    chk({tag, "_rise"}, rise, m_rise);
    chk({tag, "_fall"}, fall, m_fall);
    chk({tag, "_irq"},  irq,  m_irq);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    nreset = 1'b0; z = 1'b0; en = 1'b1; clr = 1'b0; thresh = 8'd3; irqmode = 2'b01;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_out", out, 1'b0);
    chk("reset_rise", rise, 1'b0);
    chk("reset_fall", fall, 1'b0);
    chk("reset_irq", irq, 1'b0);

    // Basic rise: z sampled at edge 1, out/rise after edge 6.
    z = 1'b1;
    nreset = 1'b1;
    ticks("t1_wait", 5);
    tick("t1_e6");
    chk("t1_out_e6", out, 1'b1);
    chk("t1_rise_e6", rise, 1'b1);
    tick("t1_e7");
    chk("t1_rise_e7", rise, 1'b0);
    clr = 1'b1;
    tick("t1_clr");
    clr = 1'b0;
    chk("t1_irq_cleared", irq, 1'b0);

    // Glitch rejection, then a just-long-enough pulse.
    z = 1'b0;
    ticks("t2_fall", 8);
    z = 1'b1;
    ticks("t2_glitch3", 3);
    z = 1'b0;
    ticks("t2_after3", 10);
    chk("t2_glitch_out", out, 1'b0);
    z = 1'b1;
    ticks("t2_pulse4", 4);
    z = 1'b0;
    ticks("t2_after4", 12);

    // thresh=0 gives 3-cycle latency; lowering thresh mid-count commits next edge.
    thresh = 8'd0;
    z = 1'b1;
    ticks("t3_t0_rise", 2);
    chk("t3_t0_out_early", out, 1'b0);
    tick("t3_t0_rise3");
    chk("t3_t0_out_rise", out, 1'b1);
    z = 1'b0;
    ticks("t3_t0_fall", 3);
    chk("t3_t0_out_fall", out, 1'b0);
    thresh = 8'd10;
    z = 1'b1;
    ticks("t3_count", 8);
    thresh = 8'd2;
    tick("t3_lowered");
    chk("t3_lowered_out", out, 1'b1);
    thresh = 8'd3;
    z = 1'b0;
    ticks("t3_back", 8);

    // IRQ modes.
    clr = 1'b1;
    tick("t4_clr0");
    clr = 1'b0;
    irqmode = 2'b01;
    z = 1'b1;
    ticks("t4_m01_rise", 8);
    chk("t4_m01_rise_irq", irq, 1'b1);
    clr = 1'b1;
    tick("t4_clr1");
    clr = 1'b0;
    z = 1'b0;
    ticks("t4_m01_fall", 8);
    chk("t4_m01_fall_irq", irq, 1'b0);
    irqmode = 2'b11;
    z = 1'b1;
    ticks("t4_m11_rise", 8);
    chk("t4_m11_rise_irq", irq, 1'b1);
    clr = 1'b1;
    tick("t4_clr2");
    clr = 1'b0;
    z = 1'b0;
    ticks("t4_m11_fall", 8);
    chk("t4_m11_fall_irq", irq, 1'b1);
    clr = 1'b1;
    tick("t4_clr3");
    clr = 1'b0;
    irqmode = 2'b00;
    z = 1'b1;
    ticks("t4_m00_rise", 8);
    z = 1'b0;
    ticks("t4_m00_fall", 8);
    chk("t4_m00_irq", irq, 1'b0);

    // Clear colliding with a set: set wins, clear takes effect next edge.
    irqmode = 2'b01;
    z = 1'b1;
    ticks("t5_wait", 5);
    clr = 1'b1;
    tick("t5_collide");
    chk("t5_collide_rise", rise, 1'b1);
    chk("t5_collide_irq", irq, 1'b1);
    tick("t5_clear");
    chk("t5_clear_irq", irq, 1'b0);
    clr = 1'b0;

    // Enable dropped mid-count, then restart from zero.
    z = 1'b0;
    ticks("t6_pend", 4);
    en = 1'b0;
    ticks("t6_dis", 5);
    chk("t6_dis_out", out, 1'b1);
    en = 1'b1;
    ticks("t6_reen", 3);
    chk("t6_reen_out_hold", out, 1'b1);
    tick("t6_reen4");
    chk("t6_reen_out", out, 1'b0);
    chk("t6_reen_fall", fall, 1'b1);

    // Asynchronous reset during PEND; held input is re-filtered from scratch.
    z = 1'b1;
    ticks("t6_rst_pend", 3);
    #2;
    nreset = 1'b0;
    #1;
    model_reset();
    chk("t6_async_out", out, 1'b0);
    chk("t6_async_rise", rise, 1'b0);
    chk("t6_async_fall", fall, 1'b0);
    chk("t6_async_irq", irq, 1'b0);
    @(posedge clk);
    #1;
    nreset = 1'b1;
    ticks("t6_refilter", 5);
    chk("t6_refilter_out_early", out, 1'b0);
    tick("t6_refilter6");
    chk("t6_refilter_rise", rise, 1'b1);
    chk("t6_refilter_out", out, 1'b1);

    // Randomized run against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) z = ~z;
      if ($urandom_range(0, 39) == 0) thresh = CNTW'($urandom_range(0, 4));
      en      = ($urandom_range(0, 19) != 0);
      clr     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) irqmode = 2'($urandom_range(0, 3));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
